seg_scan_controller: RTL and testbench
======================================

// Module: seg_scan_controller
// PURPOSE
//   Time-multiplexes the four Basys 3 seven-segment digits. Sequences a 2-bit digit index
//   through 0..3, decodes it one-hot onto active-low anodes and presents the selected
//   nibble to the downstream hex-to-segment decoder.
//   Includes a per-slot blanking window against ghosting, and tear-free double-buffered
//   display data.
// PARAMETERS
//   REFRESH_DIV   100000  clk cycles per digit slot (1 ms at 100 MHz); must be >= 2
//   BLANK_CYCLES  1000    cycles at start of each slot with all anodes off; 0 = no blanking
// PORTS
//   clk        in   1   system clock, all state on rising edge
//   rst        in   1   asynchronous, active-high reset
//   en         in   1   scan enable; 0 forces all anodes off
//   digit_en   in   4   per-digit enable, bit i gates anode i
//   load       in   1   1-cycle strobe: capture data_in into shadow register
//   data_in    in   16  four hex digits, [3:0] = digit 0 (rightmost)
//   an         out  4   anodes, active-low, one-hot-low or 4'b1111
//   nibble     out  4   active[4*idx+3 -: 4] for current idx; 0 when idle
//   digit_idx  out  2   current slot index
//   frame_tick out  1   1-cycle pulse when idx wraps 3->0
//   pending    out  1   shadow holds data not yet committed to active
// BEHAVIOUR
//   Reset (async, immediate): cnt=0, idx=0, an=4'b1111, nibble=0, frame_tick=0,
//     shadow=0, active=0, pending=0, state=IDLE.
//   States:
//     IDLE  : en=0. cnt=0, idx=0 held, an=1111, nibble=0.
//     BLANK : cnt < BLANK_CYCLES. an=1111, nibble valid.
//     DRIVE : cnt >= BLANK_CYCLES. an=~(4'b0001<<idx) if digit_en[idx], else 1111.
//   Transitions:
//     IDLE->BLANK when en=1, with cnt=0, idx=0.
//     BLANK->DRIVE when cnt reaches BLANK_CYCLES.
//     At cnt=REFRESH_DIV-1: cnt<=0, idx<=idx+1 (mod 4), back to BLANK.
//     Any state->IDLE on the first edge with en=0.
//   Outputs are flops loaded from next-state values; an/nibble/digit_idx change on the same
//     edge as cnt/idx, with no extra lag.
//   cnt width = $clog2(REFRESH_DIV). idx wraps 3->0 silently.
//   frame_tick=1 for exactly the cycle in which idx has just become 0 from 3.
//   Double buffer:
//     load=1 -> shadow<=data_in, pending<=1.
//     Commit (active<=shadow, pending<=0) on the 3->0 wrap edge and on the IDLE->BLANK edge
//       only.
//   Simultaneous load and commit: active takes the OLD shadow, shadow takes data_in,
//     pending stays 1.
//   Repeated loads before commit: the last one wins.
//   en dropped mid-slot: slot aborted, active/shadow/pending retained, idx restarts at 0.
//   digit_en changes take effect on the next edge, mid-slot allowed.
//   BLANK_CYCLES >= REFRESH_DIV: anodes never driven (legal).
//   rst asserted mid-DRIVE: an=1111 without waiting for a clock edge.
// TESTING  (REFRESH_DIV=8, BLANK_CYCLES=2)
//   1. Reset/idle:
//      rst=1 then 0 with en=0 for 50 cycles -> an=1111, nibble=0, digit_idx=0,
//      frame_tick=0 throughout.
//   2. Scan:
//      load 16'h1234, then en=1 -> per slot: 2 cycles an=1111, then 6 cycles of
//        an=1110/nib 4, 1101/nib 3, 1011/nib 2, 0111/nib 1.
//      frame_tick every 32 cycles; pending=0 after the IDLE->BLANK edge.
//   3. Tear-free:
//      load 16'hABCD during slot 1 -> slots 2..3 still show 2,1 and pending=1.
//      Frame after frame_tick shows D,C,B,A with pending=0.
//   4. Gating:
//      digit_en=4'b0101 -> an=1110 (idx0) and 1011 (idx2); idx1/idx3 slots stay 1111
//      for all 8 cycles.
//   5. Enable abort:
//      drop en at cycle 3 of slot 2 -> next edge an=1111, idx=0.
//      Reassert -> 2 blank cycles, then idx0 driven; active unchanged.
//   6. Async/collision:
//      rst mid-DRIVE between edges -> an=1111 immediately.
//      load 16'h5555 on the wrap edge while shadow=16'h9999 pending -> active=9999,
//        shadow=5555, pending=1.

Source files
------------

// File: rtl/seg_scan_controller.sv
// rtl/seg_scan_controller.sv - four-digit seven-segment scan controller with blanking and double-buffered data
//
// Purpose:
//   Walks a 2-bit digit index through 0..3, one slot of REFRESH_DIV clocks per digit.
//   The first BLANK_CYCLES clocks of each slot keep every anode off to suppress ghosting;
//   the rest drive the selected anode (active-low) if its digit_en bit is set.
//   The selected nibble of the committed display word goes to the hex decoder.
//   Display data is double-buffered: load captures into a shadow word, which is
//   committed to the active word only at frame boundaries, so a frame never tears.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   en         in   1   scan enable; 0 forces all anodes off and parks the scan at idx 0
//   digit_en   in   4   per-digit anode gate
//   load       in   1   strobe: capture data_in into the shadow word
//   data_in    in   16  four hex digits, [3:0] is digit 0 (rightmost)
//   an         out  4   active-low anodes
//   nibble     out  4   nibble of the current digit, 0 when idle
//   digit_idx  out  2   current slot index
//   frame_tick out  1   one-cycle pulse when the index wraps 3->0
//   pending    out  1   shadow holds data not yet committed

module seg_scan_controller #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  digit_en,
    input  logic        load,
    input  logic [15:0] data_in,
    output logic [3:0]  an,
    output logic [3:0]  nibble,
    output logic [1:0]  digit_idx,
    output logic        frame_tick,
    output logic        pending
);

    localparam int            CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [31:0]   BLANK_U = 32'(BLANK_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [1:0]    idx_n;
    logic [3:0]    an_n;
    logic [3:0]    nibble_n;
    logic          tick_n;
    logic          commit;
    logic [15:0]   shadow;
    logic [15:0]   shadow_n;
    logic [15:0]   active;
    logic [15:0]   active_n;
    logic          pending_n;

    // Sequencing: slot counter, digit index and state.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = digit_idx;
        commit  = 1'b0;
        tick_n  = 1'b0;

        if (!en) begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = 2'd0;
        end else if (state == IDLE) begin
            // Starting a scan commits any buffered word so the first frame is current.
            cnt_n  = '0;
            idx_n  = 2'd0;
            commit = 1'b1;
        end else if (cnt == CNT_MAX) begin
            cnt_n = '0;
            idx_n = digit_idx + 2'd1;
            if (digit_idx == 2'd3) begin
                commit = 1'b1;
                tick_n = 1'b1;
            end
        end else begin
            cnt_n = cnt + CW'(1);
        end

        // BLANK vs DRIVE follows from the new count, so the outputs below can be
        // computed from next-state values and registered without a cycle of lag.
        if (en) begin
            state_n = (32'(cnt_n) < BLANK_U) ? BLANK : DRIVE;
        end
    end

    // Double buffer. A load coinciding with a commit lands in the shadow while the
    // active word takes the previous shadow contents, leaving pending set.
    always_comb begin
        active_n  = commit ? shadow : active;
        shadow_n  = load ? data_in : shadow;
        pending_n = pending;
        if (commit) begin
            pending_n = 1'b0;
        end
        if (load) begin
            pending_n = 1'b1;
        end
    end

    // Output decode from next-state values.
    always_comb begin
        an_n     = 4'b1111;
        nibble_n = 4'h0;

        if (state_n != IDLE) begin
            case (idx_n)
                2'd0:    nibble_n = active_n[3:0];
                2'd1:    nibble_n = active_n[7:4];
                2'd2:    nibble_n = active_n[11:8];
                default: nibble_n = active_n[15:12];
            endcase
        end

        if (state_n == DRIVE && digit_en[idx_n]) begin
            an_n = ~(4'b0001 << idx_n);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            digit_idx  <= 2'd0;
            an         <= 4'b1111;
            nibble     <= 4'h0;
            frame_tick <= 1'b0;
            shadow     <= 16'h0000;
            active     <= 16'h0000;
            pending    <= 1'b0;
        end else begin
            cnt        <= cnt_n;
            digit_idx  <= idx_n;
            an         <= an_n;
            nibble     <= nibble_n;
            frame_tick <= tick_n;
            shadow     <= shadow_n;
            active     <= active_n;
            pending    <= pending_n;
        end
    end

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb/tb_seg_scan_controller.sv - self-checking bench for seg_scan_controller (REFRESH_DIV=8, BLANK_CYCLES=2)

module tb_seg_scan_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  digit_en;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  an;
    logic [3:0]  nibble;
    logic [1:0]  digit_idx;
    logic        frame_tick;
    logic        pending;

    seg_scan_controller #(
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .digit_en  (digit_en),
        .load      (load),
        .data_in   (data_in),
        .an        (an),
        .nibble    (nibble),
        .digit_idx (digit_idx),
        .frame_tick(frame_tick),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [3:0] nib;
        logic [1:0] idx;
        logic       tick;
        logic       pend;
    } exp_t;

    typedef struct {
        logic [3:0]  den;
        logic        ld;
        logic [15:0] ld_data;
        logic [3:0]  an;
        logic [3:0]  nib;
    } slot_vec_t;

    exp_t      sb[$];
    slot_vec_t vecs[16];
    int        checks = 0;
    int        errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] e_an, input logic [3:0] e_nib, input int e_idx,
                            input logic e_tick, input logic e_pend);
        exp_t e;
        e.an   = e_an;
        e.nib  = e_nib;
        e.idx  = 2'(e_idx);
        e.tick = e_tick;
        e.pend = e_pend;
        sb.push_back(e);
    endtask

    task automatic check_out(input string name);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        if (an !== e.an || nibble !== e.nib || digit_idx !== e.idx ||
            frame_tick !== e.tick || pending !== e.pend) begin
            errors++;
            $display("FAIL %s: got an=%b nib=%h idx=%0d tick=%b pend=%b, expected an=%b nib=%h idx=%0d tick=%b pend=%b",
                     name, an, nibble, digit_idx, frame_tick, pending,
                     e.an, e.nib, e.idx, e.tick, e.pend);
        end
    endtask

    task automatic cycle(input string name, input logic [3:0] e_an, input logic [3:0] e_nib,
                         input int e_idx, input logic e_tick, input logic e_pend);
        push_exp(e_an, e_nib, e_idx, e_tick, e_pend);
        step();
        check_out(name);
    endtask

    task automatic set_vec(input int i, input logic [3:0] den, input logic ld, input logic [15:0] ld_data,
                           input logic [3:0] e_an, input logic [3:0] e_nib);
        vecs[i].den     = den;
        vecs[i].ld      = ld;
        vecs[i].ld_data = ld_data;
        vecs[i].an      = e_an;
        vecs[i].nib     = e_nib;
    endtask

    initial begin
        logic       exp_pend;
        logic [3:0] e_an;
        logic [3:0] e_nib;

        // One record per slot: digit_en, optional mid-slot load, driven anode, nibble.
        set_vec(0,  4'hF, 1'b0, 16'h0000, 4'b1110, 4'h4);
        set_vec(1,  4'hF, 1'b0, 16'h0000, 4'b1101, 4'h3);
        set_vec(2,  4'hF, 1'b0, 16'h0000, 4'b1011, 4'h2);
        set_vec(3,  4'hF, 1'b0, 16'h0000, 4'b0111, 4'h1);
        set_vec(4,  4'hF, 1'b0, 16'h0000, 4'b1110, 4'h4);
        set_vec(5,  4'hF, 1'b1, 16'hABCD, 4'b1101, 4'h3);
        set_vec(6,  4'hF, 1'b0, 16'h0000, 4'b1011, 4'h2);
        set_vec(7,  4'hF, 1'b0, 16'h0000, 4'b0111, 4'h1);
        set_vec(8,  4'hF, 1'b0, 16'h0000, 4'b1110, 4'hD);
        set_vec(9,  4'hF, 1'b0, 16'h0000, 4'b1101, 4'hC);
        set_vec(10, 4'hF, 1'b0, 16'h0000, 4'b1011, 4'hB);
        set_vec(11, 4'hF, 1'b0, 16'h0000, 4'b0111, 4'hA);
        set_vec(12, 4'h5, 1'b0, 16'h0000, 4'b1110, 4'hD);
        set_vec(13, 4'h5, 1'b0, 16'h0000, 4'b1111, 4'hC);
        set_vec(14, 4'h5, 1'b0, 16'h0000, 4'b1011, 4'hB);
        set_vec(15, 4'h5, 1'b0, 16'h0000, 4'b1111, 4'hA);

        rst      = 1'b1;
        en       = 1'b0;
        digit_en = 4'hF;
        load     = 1'b0;
        data_in  = 16'h0000;

        // Reset state, then 50 idle cycles with en=0.
        #2;
        push_exp(4'b1111, 4'h0, 0, 1'b0, 1'b0);
        check_out("reset_state");
        step();
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cycle($sformatf("idle_%0d", i), 4'b1111, 4'h0, 0, 1'b0, 1'b0);
        end

        // Load while idle, then enable: the enable edge commits.
        load    = 1'b1;
        data_in = 16'h1234;
        cycle("load_idle", 4'b1111, 4'h0, 0, 1'b0, 1'b1);
        load = 1'b0;
        en   = 1'b1;

        // Table-driven frames: scan, tear-free reload, gating.
        exp_pend = 1'b1;
        for (int f = 0; f < 4; f++) begin
            for (int s = 0; s < 4; s++) begin
                digit_en = vecs[f*4+s].den;
                for (int c = 0; c < 8; c++) begin
                    load    = vecs[f*4+s].ld && (c == 3);
                    data_in = vecs[f*4+s].ld_data;
                    if (s == 0 && c == 0) exp_pend = 1'b0;
                    if (load) exp_pend = 1'b1;
                    cycle($sformatf("scan_f%0d_s%0d_c%0d", f, s, c),
                          (c < 2) ? 4'b1111 : vecs[f*4+s].an, vecs[f*4+s].nib,
                          s, (s == 0 && c == 0 && f > 0), exp_pend);
                end
            end
        end
        load     = 1'b0;
        digit_en = 4'hF;

        // Enable abort at cycle 3 of slot 2.
        for (int k = 0; k < 20; k++) begin
            e_an  = ((k % 8) < 2) ? 4'b1111 : 4'(~(4'b0001 << (k / 8)));
            e_nib = (k < 8) ? 4'hD : ((k < 16) ? 4'hC : 4'hB);
            cycle($sformatf("pre_abort_%0d", k), e_an, e_nib, k / 8, (k == 0), 1'b0);
        end
        en = 1'b0;
        cycle("abort", 4'b1111, 4'h0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle($sformatf("abort_idle_%0d", i), 4'b1111, 4'h0, 0, 1'b0, 1'b0);
        end
        en = 1'b1;
        cycle("reen_blank0", 4'b1111, 4'hD, 0, 1'b0, 1'b0);
        cycle("reen_blank1", 4'b1111, 4'hD, 0, 1'b0, 1'b0);
        cycle("reen_drive", 4'b1110, 4'hD, 0, 1'b0, 1'b0);

        // Asynchronous reset while driving.
        #2;
        rst = 1'b1;
        push_exp(4'b1111, 4'h0, 0, 1'b0, 1'b0);
        #1;
        check_out("async_rst");
        en = 1'b0;
        step();
        rst = 1'b0;

        // Load/commit collision on the wrap edge.
        en = 1'b1;
        cycle("rst_reen", 4'b1111, 4'h0, 0, 1'b0, 1'b0);
        for (int k = 1; k <= 64; k++) begin
            load    = (k == 5) || (k == 32);
            data_in = (k == 5) ? 16'h9999 : 16'h5555;
            e_an    = ((k % 8) < 2) ? 4'b1111 : 4'(~(4'b0001 << ((k / 8) % 4)));
            e_nib   = (k < 32) ? 4'h0 : ((k < 64) ? 4'h9 : 4'h5);
            cycle($sformatf("collide_%0d", k), e_an, e_nib, (k / 8) % 4,
                  ((k % 32) == 0), (k >= 5 && k < 64));
        end
        load = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
